spi_slave_ctrl: RTL and testbench

Parametrised SPI slave controller for the lab memory interface. Oversamples the SPI pins on the system clock, decodes an address/read-write command, and runs single or burst word transfers against a synchronous data memory. Address width, data width and burst behaviour are configurable. Partial words are discarded and reported when chip select is deasserted mid-word.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_slave_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave controller: FSM state encoding,
// read/write command bit value and bit-counter sizing.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      RD_FETCH,
      RD_SHIFT,
      WR_SHIFT,
      DONE
   } spi_state_t;

   localparam logic RW_READ = 1'b1;

   // Counter must hold the longest field length (command or data word).
   function automatic int cnt_width(input int addr_w, input int data_w);
      int m;
      m = ((addr_w + 1) > data_w) ? (addr_w + 1) : data_w;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchronizer with registered level and rise/fall pulses; all three
// outputs share the same SYNC_STAGES+1 clk latency from the pin.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_chain;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync;

   assign w_sync = r_chain[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
         r_level <= w_sync;
         r_rise  <= w_sync & ~r_level;
         r_fall  <= ~w_sync & r_level;
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_ctrl.sv
// Mode-0 SPI slave: oversampled pins, address/rw command decode, and single or
// burst word transfers against a synchronous memory.
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int BURST_EN    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs_pin,
   input  logic              sclk_pin,
   input  logic              mosi_pin,
   output logic              miso_out,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              frame_err
);

   localparam int              CNT_W     = cnt_width(ADDR_W, DATA_W);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   logic w_sclk_level, w_rise, w_fall;
   logic w_cs_level, w_cs_rise, w_cs_fall;
   logic w_mosi, w_mosi_rise, w_mosi_fall;
   logic w_sel;
   logic w_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk     (clk),
      .reset   (reset),
      .i_pin   (sclk_pin),
      .o_level (w_sclk_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .clk     (clk),
      .reset   (reset),
      .i_pin   (cs_pin),
      .o_level (w_cs_level),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
      .clk     (clk),
      .reset   (reset),
      .i_pin   (mosi_pin),
      .o_level (w_mosi),
      .o_rise  (w_mosi_rise),
      .o_fall  (w_mosi_fall)
   );

   assign w_sel    = ~w_cs_level;
   assign w_unused = ^{w_sclk_level, w_cs_fall, w_mosi_rise, w_mosi_fall};

   spi_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_armed;
   logic              r_fetch_wait;
   logic [ADDR_W-1:0] r_cmd;
   logic [DATA_W-1:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic              r_re;
   logic              r_ferr;

   // r_armed blocks a new frame after reset until cs has been seen high.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_armed      <= 1'b0;
         r_fetch_wait <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_re         <= 1'b0;
         r_ferr       <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_re   <= 1'b0;
         r_ferr <= 1'b0;
         if (w_cs_level) begin
            r_armed <= 1'b1;
         end

         if (w_cs_rise) begin
            if ((r_state == CMD || r_state == RD_SHIFT || r_state == WR_SHIFT) &&
                (r_cnt != '0)) begin
               r_ferr <= 1'b1;
            end
            r_state <= IDLE;
            r_cnt   <= '0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (w_sel && r_armed) begin
                     r_state <= CMD;
                     r_cnt   <= '0;
                  end
               end

               CMD: begin
                  if (w_rise) begin
                     r_cmd <= {r_cmd[ADDR_W-2:0], w_mosi};
                     if (r_cnt == CMD_LAST) begin
                        r_addr <= r_cmd;
                        r_cnt  <= '0;
                        if (w_mosi == RW_READ) begin
                           r_state      <= RD_FETCH;
                           r_re         <= 1'b1;
                           r_fetch_wait <= 1'b0;
                        end else begin
                           r_state <= WR_SHIFT;
                        end
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
               end

               // First cycle covers the mem_re pulse, second captures read data.
               RD_FETCH: begin
                  if (!r_fetch_wait) begin
                     r_fetch_wait <= 1'b1;
                  end else begin
                     r_tx    <= mem_rdata;
                     r_state <= RD_SHIFT;
                     r_cnt   <= '0;
                  end
               end

               RD_SHIFT: begin
                  if (w_rise) begin
                     if (r_cnt == DATA_LAST) begin
                        r_cnt <= '0;
                        if (BURST_EN != 0) begin
                           r_state      <= RD_FETCH;
                           r_addr       <= r_addr + ADDR_W'(1);
                           r_re         <= 1'b1;
                           r_fetch_wait <= 1'b0;
                        end else begin
                           r_state <= DONE;
                        end
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end else if (w_fall && (r_cnt != '0)) begin
                     r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                  end
               end

               WR_SHIFT: begin
                  if (w_rise) begin
                     r_rx <= {r_rx[DATA_W-2:0], w_mosi};
                     if (r_cnt == DATA_LAST) begin
                        r_wdata <= {r_rx[DATA_W-2:0], w_mosi};
                        r_we    <= 1'b1;
                        r_cnt   <= '0;
                        if (BURST_EN == 0) begin
                           r_state <= DONE;
                        end
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
                  // Address advances only after the write strobe has used it.
                  if (r_we && (BURST_EN != 0)) begin
                     r_addr <= r_addr + ADDR_W'(1);
                  end
               end

               DONE: begin
               end

               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign miso_oe   = (r_state == RD_FETCH) || (r_state == RD_SHIFT);
   assign miso_out  = miso_oe & r_tx[DATA_W-1];
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_we    = r_we;
   assign mem_re    = r_re;
   assign frame_err = r_ferr;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: default-parameter instance plus a
// 15-bit address / 16-bit data / no-burst instance on a separate chip select.
module tb_spi_slave_ctrl;

   localparam int HALF = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cs_a = 1'b1;
   logic cs_b = 1'b1;
   logic sclk = 1'b0;
   logic mosi = 1'b0;

   always #5 clk = ~clk;

   logic        a_miso, a_oe, a_we, a_re, a_ferr_o;
   logic [6:0]  a_addr;
   logic [7:0]  a_wdata;
   logic [7:0]  a_rdata = 8'h00;

   logic        b_miso, b_oe, b_we, b_re, b_ferr_o;
   logic [14:0] b_addr;
   logic [15:0] b_wdata;
   logic [15:0] b_rdata = 16'h0000;

   spi_slave_ctrl u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .cs_pin    (cs_a),
      .sclk_pin  (sclk),
      .mosi_pin  (mosi),
      .miso_out  (a_miso),
      .miso_oe   (a_oe),
      .mem_addr  (a_addr),
      .mem_wdata (a_wdata),
      .mem_we    (a_we),
      .mem_re    (a_re),
      .mem_rdata (a_rdata),
      .frame_err (a_ferr_o)
   );

   spi_slave_ctrl #(
      .ADDR_W      (15),
      .DATA_W      (16),
      .SYNC_STAGES (2),
      .BURST_EN    (0)
   ) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .cs_pin    (cs_b),
      .sclk_pin  (sclk),
      .mosi_pin  (mosi),
      .miso_out  (b_miso),
      .miso_oe   (b_oe),
      .mem_addr  (b_addr),
      .mem_wdata (b_wdata),
      .mem_we    (b_we),
      .mem_re    (b_re),
      .mem_rdata (b_rdata),
      .frame_err (b_ferr_o)
   );

   logic [7:0] mem_a [128];

   always @(posedge clk) begin
      if (a_re) a_rdata <= mem_a[a_addr];
      if (a_we) mem_a[a_addr] <= a_wdata;
   end

   function automatic logic [15:0] bval(input logic [14:0] ad);
      return {ad[7:0], ~ad[14:7]};
   endfunction

   always @(posedge clk) begin
      if (b_re) b_rdata <= bval(b_addr);
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t         q_wr_a[$];
   logic [15:0] q_re_a[$];
   logic [15:0] q_re_b[$];
   logic        q_miso[$];
   int          a_ferr_n = 0;
   int          b_ferr_n = 0;
   int          b_re_n   = 0;
   bit          cur_b    = 1'b0;

   always @(negedge clk) begin
      wr_t e;
      if (a_we) begin
         if (q_wr_a.size() == 0) check("a_we_unexpected", 32'(a_we), 32'd0);
         else begin
            e = q_wr_a.pop_front();
            check("a_we_addr", 32'(a_addr), 32'(e.addr));
            check("a_we_data", 32'(a_wdata), 32'(e.data));
         end
      end
      if (a_re) begin
         if (q_re_a.size() == 0) check("a_re_unexpected", 32'(a_re), 32'd0);
         else check("a_re_addr", 32'(a_addr), 32'(q_re_a.pop_front()));
      end
      if (a_ferr_o) a_ferr_n++;
      if (b_we) check("b_we_unexpected", 32'(b_we), 32'd0);
      if (b_re) begin
         b_re_n++;
         if (q_re_b.size() == 0) check("b_re_unexpected", 32'(b_re), 32'd0);
         else check("b_re_addr", 32'(b_addr), 32'(q_re_b.pop_front()));
      end
      if (b_ferr_o) b_ferr_n++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_start(input bit use_b);
      cur_b = use_b;
      if (use_b) cs_b = 1'b0;
      else cs_a = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic frame_end();
      wait_clk(HALF);
      cs_a = 1'b1;
      cs_b = 1'b1;
      wait_clk(3 * HALF);
   endtask

   task automatic push_bits(input int n, input logic [63:0] v);
      for (int i = n - 1; i >= 0; i--) q_miso.push_back(v[i]);
   endtask

   // mode 0: drive only, 1: check miso against the queue, 2: expect miso_oe low
   task automatic send(input int n, input logic [63:0] v, input int mode);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = v[i];
         wait_clk(HALF);
         sclk = 1'b1;
         if (mode == 1) begin
            check("miso_oe_on", 32'(cur_b ? b_oe : a_oe), 32'd1);
            check("miso_bit", 32'(cur_b ? b_miso : a_miso), 32'(q_miso.pop_front()));
         end else if (mode == 2) begin
            check("miso_oe_off", 32'(cur_b ? b_oe : a_oe), 32'd0);
         end
         wait_clk(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic check_a_reset(input string tag);
      check({tag, "_miso"},  32'(a_miso), 32'd0);
      check({tag, "_oe"},    32'(a_oe), 32'd0);
      check({tag, "_addr"},  32'(a_addr), 32'd0);
      check({tag, "_wdata"}, 32'(a_wdata), 32'd0);
      check({tag, "_we"},    32'(a_we), 32'd0);
      check({tag, "_re"},    32'(a_re), 32'd0);
      check({tag, "_ferr"},  32'(a_ferr_o), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem_a[i] = 8'h00;
      wait_clk(4);
      reset = 1'b0;
      wait_clk(1);
      check_a_reset("rst");
      check("rst_b_oe", 32'(b_oe), 32'd0);
      wait_clk(2 * HALF);

      // single write
      q_wr_a.push_back({16'h0005, 16'h00A5});
      frame_start(1'b0);
      send(8, 64'h0A, 0);
      send(8, 64'hA5, 0);
      frame_end();
      check("wr_pending", 32'(q_wr_a.size()), 32'd0);
      check("wr_ferr", 32'(a_ferr_n), 32'd0);

      // read with burst prefetch of the next address
      mem_a[7'h12] = 8'h3C;
      q_re_a.push_back(16'h0012);
      q_re_a.push_back(16'h0013);
      push_bits(8, 64'h3C);
      frame_start(1'b0);
      send(8, 64'h25, 0);
      send(8, 64'h00, 1);
      frame_end();
      check("rd_pending", 32'(q_re_a.size()), 32'd0);
      check("rd_miso_left", 32'(q_miso.size()), 32'd0);
      check("rd_ferr", 32'(a_ferr_n), 32'd0);

      // burst write wrapping past the top address
      q_wr_a.push_back({16'h007F, 16'h0011});
      q_wr_a.push_back({16'h0000, 16'h0022});
      q_wr_a.push_back({16'h0001, 16'h0033});
      frame_start(1'b0);
      send(8, 64'hFE, 0);
      send(24, 64'h112233, 0);
      frame_end();
      check("burst_pending", 32'(q_wr_a.size()), 32'd0);
      check("burst_ferr", 32'(a_ferr_n), 32'd0);
      check("burst_mem00", 32'(mem_a[0]), 32'h22);

      // abort after 5 data bits, then a clean frame
      frame_start(1'b0);
      send(8, 64'h80, 0);
      send(5, 64'h15, 0);
      frame_end();
      check("abort_ferr", 32'(a_ferr_n), 32'd1);
      q_wr_a.push_back({16'h0041, 16'h005A});
      frame_start(1'b0);
      send(8, 64'h82, 0);
      send(8, 64'h5A, 0);
      frame_end();
      check("after_abort_pending", 32'(q_wr_a.size()), 32'd0);
      check("after_abort_ferr", 32'(a_ferr_n), 32'd1);

      // reset in the middle of a command; rest of the frame is ignored
      frame_start(1'b0);
      send(4, 64'hA, 0);
      reset = 1'b1;
      wait_clk(1);
      check_a_reset("midrst");
      reset = 1'b0;
      send(4, 64'h6, 0);
      send(8, 64'hFF, 0);
      frame_end();
      check("midrst_ferr", 32'(a_ferr_n), 32'd1);
      check("midrst_mem53", 32'(mem_a[7'h53]), 32'd0);
      q_wr_a.push_back({16'h0033, 16'h00C3});
      frame_start(1'b0);
      send(8, 64'h66, 0);
      send(8, 64'hC3, 0);
      frame_end();
      check("post_rst_pending", 32'(q_wr_a.size()), 32'd0);

      // wide, non-burst read: one fetch, output disabled after the word
      q_re_b.push_back(16'h1234);
      push_bits(16, 64'(bval(15'h1234)));
      frame_start(1'b1);
      send(16, 64'({15'h1234, 1'b1}), 0);
      send(16, 64'h0, 1);
      send(16, 64'h0, 2);
      frame_end();
      check("b_re_count", 32'(b_re_n), 32'd1);
      check("b_re_pending", 32'(q_re_b.size()), 32'd0);
      check("b_miso_left", 32'(q_miso.size()), 32'd0);
      check("b_ferr", 32'(b_ferr_n), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
